// File: rtl/xbus_arbiter.sv
// Two-master xbus arbiter: combinational grant with round-robin or fixed tie-break,
// plus a bounded lock so one master can own the bus for an atomic sequence.
module xbus_arbiter #(
    parameter int LOCK_MAX   = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_as,
    input  logic        m0_lock,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_wait,
    input  logic        m1_as,
    input  logic        m1_lock,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_wait,
    output logic        s_as,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic [1:0]  gnt,
    output logic        lock_timeout
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    // lock_cnt counts owned cycles before the current one, so the cycle seeing
    // LOCK_MAX-1 is the LOCK_MAX-th and final owned cycle of the sequence.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {ARB = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} st_t;

    st_t              st, st_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] lock_cnt, cnt_nxt;
    logic             to_nxt;
    logic             own_idx, own_lock;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st           <= ARB;
            last         <= 1'b1;
            lock_cnt     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            st           <= st_nxt;
            last         <= last_nxt;
            lock_cnt     <= cnt_nxt;
            lock_timeout <= to_nxt;
        end
    end

    always_comb begin
        st_nxt   = st;
        last_nxt = last;
        cnt_nxt  = lock_cnt;
        to_nxt   = 1'b0;
        own_idx  = (st == LOCK1);
        own_lock = own_idx ? m1_lock : m0_lock;
        if (gnt[0])
            last_nxt = 1'b0;
        else if (gnt[1])
            last_nxt = 1'b1;
        case (st)
            ARB: begin
                if (gnt[0] && m0_lock) begin
                    st_nxt  = LOCK0;
                    cnt_nxt = CNT_W'(1);
                end else if (gnt[1] && m1_lock) begin
                    st_nxt  = LOCK1;
                    cnt_nxt = CNT_W'(1);
                end
            end
            LOCK0, LOCK1: begin
                if (lock_cnt == CNT_LAST) begin
                    // Forced release: treat the owner as last so the other master wins the next tie.
                    st_nxt   = ARB;
                    cnt_nxt  = '0;
                    to_nxt   = 1'b1;
                    last_nxt = own_idx;
                end else if (!own_lock) begin
                    st_nxt  = ARB;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = lock_cnt + CNT_W'(1);
                end
            end
            default: begin
                st_nxt  = ARB;
                cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (st)
                ARB: begin
                    if (m0_as && m1_as)
                        gnt = ((FIXED_PRIO != 0) || last) ? 2'b01 : 2'b10;
                    else
                        gnt = {m1_as, m0_as};
                end
                LOCK0:   gnt = {1'b0, m0_as};
                LOCK1:   gnt = {m1_as, 1'b0};
                default: gnt = 2'b00;
            endcase
        end
        s_as    = 1'b0;
        s_we    = 1'b0;
        s_be    = '0;
        s_addr  = '0;
        s_wdata = '0;
        if (gnt[0]) begin
            s_as    = 1'b1;
            s_we    = m0_we;
            s_be    = m0_be;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
        end else if (gnt[1]) begin
            s_as    = 1'b1;
            s_we    = m1_we;
            s_be    = m1_be;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
        end
        m0_rdata = gnt[0] ? s_rdata : '0;
        m1_rdata = gnt[1] ? s_rdata : '0;
        m0_wait  = m0_as & ~gnt[0];
        m1_wait  = m1_as & ~gnt[1];
    end
endmodule
